// File: rtl/branch_resolve_mp.sv
// branch_resolve_mp: multi-port branch/jump resolution with an in-order result FIFO toward the frontend.
module branch_resolve_mp #(
  parameter int unsigned VLEN    = 39,
  parameter int unsigned NrPorts = 2,
  parameter int unsigned Depth   = 4,
  parameter bit          RVC     = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  output logic                             ready_o,
  input  logic [NrPorts-1:0]               valid_i,
  input  logic [NrPorts-1:0]               is_branch_i,
  input  logic [NrPorts-1:0]               is_jalr_i,
  input  logic [NrPorts-1:0][VLEN-1:0]     pc_i,
  input  logic [NrPorts-1:0][VLEN-1:0]     imm_i,
  input  logic [NrPorts-1:0][VLEN-1:0]     rs1_i,
  input  logic [NrPorts-1:0]               cmp_res_i,
  input  logic [NrPorts-1:0]               compressed_i,
  input  logic [NrPorts-1:0]               pred_taken_i,
  input  logic [NrPorts-1:0][VLEN-1:0]     pred_addr_i,
  output logic [NrPorts-1:0]               link_valid_o,
  output logic [NrPorts-1:0][VLEN-1:0]     link_o,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic [VLEN-1:0]                  res_pc_o,
  output logic [VLEN-1:0]                  res_target_o,
  output logic                             res_taken_o,
  output logic                             res_mispredict_o,
  output logic                             res_misaligned_o
);
  localparam int unsigned PW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  typedef enum logic {RUN, SQUASH} state_e;
  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target;
    logic            taken;
    logic            mispredict;
    logic            misaligned;
  } entry_t;

  state_e                        state_q, state_d;
  logic [CW-1:0]                 count_q, count_d, npush;
  logic [PW-1:0]                 wptr_q, wptr_d, rptr_q, rptr_d;
  logic [NrPorts-1:0][PW-1:0]    slot;
  logic [NrPorts-1:0]            en, link_valid_q;
  logic [NrPorts-1:0][VLEN-1:0]  npc, link_q;
  entry_t [NrPorts-1:0]          ent;
  entry_t                        mem_q [Depth];
  logic                          bad, pop;

  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    logic [VLEN-1:0] tgt;
    logic            tk;
    assign npc[p] = pc_i[p] + (compressed_i[p] ? VLEN'(2) : VLEN'(4));
    assign tgt = ((is_jalr_i[p] ? rs1_i[p] : pc_i[p]) + imm_i[p]) & ~VLEN'(is_jalr_i[p]);
    assign tk = is_branch_i[p] ? cmp_res_i[p] : 1'b1;
    assign ent[p] = '{pc: pc_i[p], target: tk ? tgt : npc[p], taken: tk,
                      mispredict: (tk != pred_taken_i[p]) || (tk && pred_taken_i[p] && tgt != pred_addr_i[p]),
                      misaligned: !RVC && tk && tgt[1]};
  end

  assign ready_o     = state_q == RUN && (CW'(Depth) - count_q) >= CW'(NrPorts);
  assign res_valid_o = count_q != '0;
  assign pop         = res_valid_o && res_ready_i;
  assign {res_pc_o, res_target_o, res_taken_o, res_mispredict_o, res_misaligned_o} =
    res_valid_o ? mem_q[rptr_q] : '0;
  assign link_valid_o = link_valid_q;
  assign link_o       = link_q;

  // A mispredicting or misaligned port kills every higher-index port in the same cycle.
  always_comb begin
    en      = '0;
    slot    = '0;
    npush   = '0;
    bad     = 1'b0;
    for (int p = 0; p < NrPorts; p++) begin
      en[p]   = valid_i[p] && ready_o && !flush_i && !bad;
      slot[p] = PW'((32'(wptr_q) + 32'(npush)) % Depth);
      npush   = npush + CW'(en[p]);
      bad     = bad || (en[p] && (ent[p].mispredict || ent[p].misaligned));
    end
    state_d = flush_i ? RUN : (bad ? SQUASH : state_q);
    count_d = flush_i ? '0 : count_q + npush - CW'(pop);
    wptr_d  = flush_i ? '0 : PW'((32'(wptr_q) + 32'(npush)) % Depth);
    rptr_d  = flush_i ? '0 : (pop ? PW'((32'(rptr_q) + 32'd1) % Depth) : rptr_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      for (int p = 0; p < NrPorts; p++) if (en[p]) mem_q[slot[p]] <= ent[p];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      link_valid_q <= '0;
      link_q       <= '0;
    end else begin
      link_valid_q <= en;
      for (int p = 0; p < NrPorts; p++) if (en[p]) link_q[p] <= npc[p];
    end
  end
endmodule

// File: tb/tb_branch_resolve_mp.sv
// tb_branch_resolve_mp: directed table vectors plus hand-written FIFO/squash/flush/reset sequences.
module tb_branch_resolve_mp;
  localparam int VL = 40;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, res_ready = 1'b0;
  logic [1:0] valid, is_br, is_jalr, cmp, cmpr, pt;
  logic [1:0][VL-1:0] pc, imm, rs1, pa;
  logic ready, res_valid, res_taken, res_mp, res_ma;
  logic [1:0] link_valid;
  logic [1:0][VL-1:0] link;
  logic [VL-1:0] res_pc, res_tgt;
  logic r0_ready, r0_valid, r0_taken, r0_mp, r0_ma;
  logic [1:0] r0_lv;
  logic [1:0][VL-1:0] r0_link;
  logic [VL-1:0] r0_pc, r0_tgt;
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  branch_resolve_mp #(.VLEN(VL), .NrPorts(2), .Depth(4), .RVC(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .ready_o(ready), .valid_i(valid),
    .is_branch_i(is_br), .is_jalr_i(is_jalr), .pc_i(pc), .imm_i(imm), .rs1_i(rs1),
    .cmp_res_i(cmp), .compressed_i(cmpr), .pred_taken_i(pt), .pred_addr_i(pa),
    .link_valid_o(link_valid), .link_o(link), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_pc_o(res_pc), .res_target_o(res_tgt), .res_taken_o(res_taken),
    .res_mispredict_o(res_mp), .res_misaligned_o(res_ma));

  branch_resolve_mp #(.VLEN(VL), .NrPorts(2), .Depth(4), .RVC(1'b0)) u_rvc0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .ready_o(r0_ready), .valid_i(valid),
    .is_branch_i(is_br), .is_jalr_i(is_jalr), .pc_i(pc), .imm_i(imm), .rs1_i(rs1),
    .cmp_res_i(cmp), .compressed_i(cmpr), .pred_taken_i(pt), .pred_addr_i(pa),
    .link_valid_o(r0_lv), .link_o(r0_link), .res_valid_o(r0_valid), .res_ready_i(res_ready),
    .res_pc_o(r0_pc), .res_target_o(r0_tgt), .res_taken_o(r0_taken),
    .res_mispredict_o(r0_mp), .res_misaligned_o(r0_ma));

  typedef struct {
    logic br, jalr, cm, c, ptk;
    logic [VL-1:0] vpc, vimm, vrs1, vpa;
    logic [VL-1:0] e_tgt;
    logic e_tk, e_mp, e_ma0;
    logic [VL-1:0] e_link;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid = '0; is_br = '0; is_jalr = '0; cmp = '0; cmpr = '0; pt = '0;
    pc = '0; imm = '0; rs1 = '0; pa = '0;
  endtask

  task automatic drv(input int p, input logic br, input logic jalr, input logic cm, input logic c,
                     input logic ptk, input logic [VL-1:0] vpc, input logic [VL-1:0] vimm,
                     input logic [VL-1:0] vrs1, input logic [VL-1:0] vpa);
    valid[p] = 1'b1; is_br[p] = br; is_jalr[p] = jalr; cmp[p] = cm; cmpr[p] = c; pt[p] = ptk;
    pc[p] = vpc; imm[p] = vimm; rs1[p] = vrs1; pa[p] = vpa;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    clr();
    v[0] = '{1, 0, 1, 0, 1, 40'h1000, 40'h20, 40'h0, 40'h1020, 40'h1020, 1, 0, 0, 40'h1004};
    v[1] = '{1, 0, 0, 0, 0, 40'h2000, 40'h40, 40'h0, 40'h0, 40'h2004, 0, 0, 0, 40'h2004};
    v[2] = '{1, 0, 1, 0, 0, 40'h3000, 40'h10, 40'h0, 40'h0, 40'h3010, 1, 1, 0, 40'h3004};
    v[3] = '{1, 0, 0, 0, 1, 40'h3000, 40'h10, 40'h0, 40'h3010, 40'h3004, 0, 1, 0, 40'h3004};
    v[4] = '{1, 0, 1, 0, 1, 40'h4000, 40'h8, 40'h0, 40'h4004, 40'h4008, 1, 1, 0, 40'h4004};
    v[5] = '{0, 1, 0, 0, 1, 40'h500, 40'h0, 40'h2003, 40'h2000, 40'h2002, 1, 1, 1, 40'h504};
    v[6] = '{0, 0, 0, 0, 1, 40'h100, 40'h6, 40'h0, 40'h106, 40'h106, 1, 0, 1, 40'h104};
    v[7] = '{1, 0, 0, 1, 0, 40'hFF_FFFF_FFFE, 40'h10, 40'h0, 40'h0, 40'h0, 0, 0, 0, 40'h0};
    v[8] = '{0, 0, 0, 1, 1, 40'h200, 40'hFF_FFFF_FFFC, 40'h0, 40'h1FC, 40'h1FC, 1, 0, 0, 40'h202};
    v[9] = '{0, 1, 0, 0, 1, 40'h800, 40'hFF_FFFF_FFFF, 40'h1006, 40'h1004, 40'h1004, 1, 0, 0, 40'h804};
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_link_valid", 64'(link_valid), 64'd0);
    chk("rst_link", 64'(link[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_ready", 64'(ready), 64'd1);
    tick();
    chk("idle_res_valid", 64'(res_valid), 64'd0);

    for (int i = 0; i < 10; i++) begin
      do_flush();
      drv(0, v[i].br, v[i].jalr, v[i].cm, v[i].c, v[i].ptk, v[i].vpc, v[i].vimm, v[i].vrs1, v[i].vpa);
      tick();
      clr();
      chk($sformatf("v%0d_valid", i), 64'(res_valid), 64'd1);
      chk($sformatf("v%0d_pc", i), 64'(res_pc), 64'(v[i].vpc));
      chk($sformatf("v%0d_target", i), 64'(res_tgt), 64'(v[i].e_tgt));
      chk($sformatf("v%0d_taken", i), 64'(res_taken), 64'(v[i].e_tk));
      chk($sformatf("v%0d_mispredict", i), 64'(res_mp), 64'(v[i].e_mp));
      chk($sformatf("v%0d_misaligned_rvc1", i), 64'(res_ma), 64'd0);
      chk($sformatf("v%0d_misaligned_rvc0", i), 64'(r0_ma), 64'(v[i].e_ma0));
      chk($sformatf("v%0d_link_valid", i), 64'(link_valid), 64'd1);
      chk($sformatf("v%0d_link", i), 64'(link[0]), 64'(v[i].e_link));
      chk($sformatf("v%0d_ready_rvc1", i), 64'(ready), 64'(!v[i].e_mp));
      chk($sformatf("v%0d_ready_rvc0", i), 64'(r0_ready), 64'(!(v[i].e_mp || v[i].e_ma0)));
      tick();
      chk($sformatf("v%0d_link_valid_drop", i), 64'(link_valid), 64'd0);
    end

    // mispredicting JALR on port 0 drops port 1 and squashes until flush
    do_flush();
    drv(0, 0, 1, 0, 0, 1, 40'h500, 40'h0, 40'h2003, 40'h2000);
    drv(1, 1, 0, 0, 0, 0, 40'h600, 40'h10, 40'h0, 40'h0);
    tick();
    clr();
    chk("sq_target", 64'(res_tgt), 64'h2002);
    chk("sq_mispredict", 64'(res_mp), 64'd1);
    chk("sq_link_valid", 64'(link_valid), 64'b01);
    chk("sq_ready", 64'(ready), 64'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("sq_port1_dropped", 64'(res_valid), 64'd0);
    chk("sq_ready_held", 64'(ready), 64'd0);
    drv(0, 1, 0, 0, 0, 0, 40'h700, 40'h0, 40'h0, 40'h0);
    tick();
    clr();
    chk("sq_no_accept", 64'(res_valid), 64'd0);
    chk("sq_no_link", 64'(link_valid), 64'd0);
    do_flush();
    chk("sq_flush_ready", 64'(ready), 64'd1);
    chk("sq_flush_empty", 64'(res_valid), 64'd0);

    // flush beats a simultaneous pop and drops the flush-cycle inputs
    drv(0, 1, 0, 0, 0, 0, 40'h900, 40'h0, 40'h0, 40'h0);
    tick();
    drv(1, 1, 0, 0, 0, 0, 40'h904, 40'h0, 40'h0, 40'h0);
    flush = 1'b1;
    res_ready = 1'b1;
    tick();
    flush = 1'b0;
    res_ready = 1'b0;
    clr();
    chk("fl_empty", 64'(res_valid), 64'd0);
    chk("fl_link_valid", 64'(link_valid), 64'd0);
    tick();
    chk("fl_still_empty", 64'(res_valid), 64'd0);
    chk("fl_ready", 64'(ready), 64'd1);

    // fill to Depth, back-pressure, then wrap the pointers
    for (int c = 0; c < 2; c++) begin
      drv(0, 1, 0, 0, 0, 0, 40'hA00 + 40'(8 * c), 40'h0, 40'h0, 40'h0);
      drv(1, 1, 0, 0, 0, 0, 40'hA04 + 40'(8 * c), 40'h0, 40'h0, 40'h0);
      tick();
      chk($sformatf("fill%0d_ready", c), 64'(ready), 64'(c == 0));
      chk($sformatf("fill%0d_link1", c), 64'(link[1]), 64'hA08 + 64'(8 * c));
    end
    res_ready = 1'b1;
    tick();
    chk("bp_pop1_ready", 64'(ready), 64'd0);
    chk("bp_pop1_no_link", 64'(link_valid), 64'd0);
    chk("bp_pop1_head", 64'(res_pc), 64'hA04);
    clr();
    tick();
    res_ready = 1'b0;
    chk("bp_pop2_ready", 64'(ready), 64'd1);
    chk("bp_pop2_head", 64'(res_pc), 64'hA08);
    drv(0, 1, 0, 0, 0, 0, 40'hB00, 40'h0, 40'h0, 40'h0);
    drv(1, 1, 0, 0, 0, 0, 40'hB04, 40'h0, 40'h0, 40'h0);
    tick();
    clr();
    chk("wrap_full_ready", 64'(ready), 64'd0);
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [VL-1:0] exp_pc;
      exp_pc = (k == 0) ? 40'hA08 : (k == 1) ? 40'hA0C : (k == 2) ? 40'hB00 : 40'hB04;
      chk($sformatf("wrap_head%0d", k), 64'(res_pc), 64'(exp_pc));
      tick();
    end
    res_ready = 1'b0;
    chk("wrap_drained", 64'(res_valid), 64'd0);

    // asynchronous reset mid-stream discards contents immediately
    drv(0, 1, 0, 0, 0, 0, 40'hC00, 40'h0, 40'h0, 40'h0);
    tick();
    clr();
    chk("ar_pre_valid", 64'(res_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_res_valid", 64'(res_valid), 64'd0);
    chk("ar_res_pc", 64'(res_pc), 64'd0);
    chk("ar_link_valid", 64'(link_valid), 64'd0);
    tick();
    rst = 1'b0;
    chk("ar_ready", 64'(ready), 64'd1);
    tick();
    chk("ar_empty", 64'(res_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
